hwpe_ctrl_periph_slv: RTL and testbench
=======================================

Name: hwpe_ctrl_periph_slv

Overview:
- Responder end of the 32-bit TCDM-style HWPE control port that the narrow-AXI-to-TCDM bridge drives inside the cluster tile.
- Decodes register reads and writes and holds the job parameters.
- Runs a job FSM that issues start pulses to the accelerator datapath and collects its done signal.
- Raises masked per-core events (mxip) on job completion.

Parameters:
- AddrWidth, 32, request address width.
- DataWidth, 32, data width; only 32 is supported.
- NrCores, 9, width of the event output.
- NumParams, 8, number of RW job-parameter registers (1..24).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- q_valid_i  in  1  request valid.
- q_ready_o  out  1  request ready.
- q_addr_i  in  AddrWidth  byte address; only bits [7:2] are decoded.
- q_write_i  in  1  1 = write, 0 = read.
- q_data_i  in  DataWidth  write data.
- q_strb_i  in  DataWidth/8  byte enables.
- p_valid_o  out  1  response valid.
- p_data_o  out  DataWidth  read data; 0 for writes.
- job_start_o  out  1  one-cycle start pulse to the datapath.
- job_done_i  in  1  one-cycle done pulse from the datapath.
- params_o  out  NumParams*DataWidth  parameter registers, flattened, reg0 in the LSBs.
- evt_o  out  NrCores  per-core event pulse.

Behaviour:
- Reset (async assert, sync release): FSM=IDLE, all registers 0. All outputs 0, including q_ready_o.
- First cycle after reset release: q_ready_o=1.
- Handshake:
  - A request is accepted when q_valid_i & q_ready_o.
  - p_valid_o is asserted exactly 1 cycle after acceptance, for 1 cycle; p_data_o is valid in that cycle.
  - The response path has no backpressure.
  - Back-to-back requests are accepted every cycle.
  - q_ready_o is low only in the single cycle after a TRIGGER write is accepted (the START cycle).
- Register map (byte offsets):
  - 0x00 TRIGGER: WO. Any write in IDLE starts a job. Reads return 0.
  - 0x04 STATUS: RO. bit0=busy, bit1=done (sticky), bit2=rejected (sticky: trigger written while busy).
  - 0x08 SOFT_CLR: WO. bit0 clears done, bit1 clears CYCLES, bit2 clears rejected.
  - 0x0C CYCLES: RO. Busy-cycle count of the last or current job.
  - 0x10 EVT_MASK: RW, NrCores LSBs. Upper bits read 0.
  - 0x20+4*i PARAM[i]: RW, i<NumParams.
  - Any other offset: reads 0, writes ignored.
- Strobes:
  - Byte writes apply per q_strb_i on RW registers.
  - On TRIGGER and SOFT_CLR, an action fires if any strobe bit is set; SOFT_CLR uses byte 0 only.
- FSM:
  - IDLE: on TRIGGER write -> START; CYCLES cleared to 0.
  - START (1 cycle): job_start_o=1 -> BUSY.
  - BUSY: CYCLES increments each cycle, saturating at 0xFFFFFFFF (no wrap). On job_done_i -> DONE.
  - DONE (1 cycle): done bit set; evt_o=EVT_MASK for 1 cycle -> IDLE.
  - job_done_i outside BUSY is ignored.
- busy = (FSM != IDLE).
- A TRIGGER write while busy is dropped and sets rejected. It is not queued.
- PARAM writes while busy are accepted. params_o is combinational from the registers; the datapath samples them on job_start_o.
- Simultaneous events:
  - SOFT_CLR bit0 in the same cycle as the done-set: set wins.
  - SOFT_CLR bit1 while BUSY: CYCLES is cleared that cycle, then counting resumes.
- Reads return register values as they were before any same-cycle write.
- Reset mid-job: FSM returns to IDLE and no evt_o is issued. A response pending at reset is lost; p_valid_o=0.

Optional Feature:
- Macro: HWPE_CTRL_ERR_EN.
- When defined:
  - Adds output p_err_o (1 bit), timed with p_valid_o.
  - p_err_o=1 for accesses to unmapped offsets, writes to RO registers, and reads of WO registers.
  - p_err_o=1 for a TRIGGER write while busy; rejected is set as well.
  - Reset value of p_err_o: 0.
- When undefined: no p_err_o port; these accesses complete silently as described in Behaviour.

Test Plan:
- Reset, then read 0x04 and 0x0C -> p_valid_o 1 cycle later with data 0; q_ready_o=1.
- Write 0x20=0xDEADBEEF with strb=0b0101 -> a read of 0x20 returns 0x00AD00EF; params_o[31:0]=0x00AD00EF.
- Write 0x10=0x1FF, write 0x00; drive job_done_i 10 cycles after job_start_o:
  - job_start_o pulses once.
  - q_ready_o=0 for 1 cycle.
  - STATUS reads 0x1 during the job; CYCLES=10 afterwards.
  - evt_o=0x1FF for 1 cycle; STATUS=0x2.
- Write 0x00 while BUSY -> no second job_start_o; STATUS bit2=1. Write 0x08=0x4 -> bit2 clears.
- Same cycle: job_done_i-driven done-set and a SOFT_CLR write of 0x1 -> STATUS bit1=1 afterwards.
- Assert rst_i mid-BUSY -> evt_o stays 0; after release, STATUS=0 and params_o=0.
- With HWPE_CTRL_ERR_EN: read 0x40 -> p_err_o=1 with data 0; write 0x0C -> p_err_o=1 and CYCLES is unchanged.

Source files
------------

// File: rtl/hwpe_ctrl_periph_slv.sv
// HWPE control-port responder: register decode, job parameters, job FSM and per-core events.
// Optional HWPE_CTRL_ERR_EN adds p_err_o flagging unmapped/illegal accesses and rejected triggers.
module hwpe_ctrl_periph_slv #(
   parameter int unsigned AddrWidth = 32,
   parameter int unsigned DataWidth = 32,
   parameter int unsigned NrCores   = 9,
   parameter int unsigned NumParams = 8
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           q_valid_i,
   output logic                           q_ready_o,
   input  logic [AddrWidth-1:0]           q_addr_i,
   input  logic                           q_write_i,
   input  logic [DataWidth-1:0]           q_data_i,
   input  logic [DataWidth/8-1:0]         q_strb_i,
   output logic                           p_valid_o,
   output logic [DataWidth-1:0]           p_data_o,
   output logic                           job_start_o,
   input  logic                           job_done_i,
   output logic [NumParams*DataWidth-1:0] params_o,
`ifdef HWPE_CTRL_ERR_EN
   output logic                           p_err_o,
`endif
   output logic [NrCores-1:0]             evt_o
);

   localparam int unsigned NB = DataWidth / 8;

   typedef enum logic [1:0] {IDLE, START, BUSY, DONE} state_e;

   state_e                 state_q, state_d;
   logic                   rdy_q;
   logic                   p_valid_q;
   logic [DataWidth-1:0]   p_data_q;
   logic                   done_q, rej_q;
   logic [31:0]            cycles_q;
   logic [NrCores-1:0]     evt_mask_q;
   logic [DataWidth-1:0]   params_q [NumParams];

   logic [5:0]             off;
   logic                   accept, wr_acc, rd_acc, busy;
   logic                   trig_wr, trig_fire, trig_rej, clr_wr;
   logic                   is_param;
   logic [DataWidth-1:0]   rdata;
   logic [DataWidth-1:0]   mask_wdata;
   logic                   unused_addr;

   function automatic logic [DataWidth-1:0] merge(input logic [DataWidth-1:0] old_v,
                                                  input logic [DataWidth-1:0] new_v,
                                                  input logic [NB-1:0]        strb);
      logic [DataWidth-1:0] r;
      r = old_v;
      for (int unsigned b = 0; b < NB; b++) begin
         if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
      end
      return r;
   endfunction

   assign off         = q_addr_i[7:2];
   assign unused_addr = ^{q_addr_i[AddrWidth-1:8], q_addr_i[1:0]};

   // Ready drops only in START so the job launch never overlaps a register access.
   assign q_ready_o = rdy_q & (state_q != START);
   assign accept    = q_valid_i & q_ready_o;
   assign wr_acc    = accept & q_write_i;
   assign rd_acc    = accept & ~q_write_i;
   assign busy      = (state_q != IDLE);

   assign trig_wr   = wr_acc & (off == 6'h00) & (|q_strb_i);
   assign trig_fire = trig_wr & ~busy;
   assign trig_rej  = trig_wr & busy;
   assign clr_wr    = wr_acc & (off == 6'h02) & q_strb_i[0];

   assign job_start_o = (state_q == START);
   assign evt_o       = (state_q == DONE) ? evt_mask_q : '0;
   assign p_valid_o   = p_valid_q;
   assign p_data_o    = p_data_q;

   for (genvar g = 0; g < NumParams; g++) begin : g_params
      assign params_o[g*DataWidth +: DataWidth] = params_q[g];
   end

   always_comb begin
      is_param = 1'b0;
      for (int unsigned i = 0; i < NumParams; i++) begin
         if (off == 6'(8 + i)) is_param = 1'b1;
      end
   end

   always_comb begin
      rdata = '0;
      case (off)
         6'h01:   rdata[2:0] = {rej_q, done_q, busy};
         6'h03:   rdata = cycles_q;
         6'h04:   rdata[NrCores-1:0] = evt_mask_q;
         default: begin
            for (int unsigned i = 0; i < NumParams; i++) begin
               if (off == 6'(8 + i)) rdata = params_q[i];
            end
         end
      endcase
   end

   always_comb mask_wdata = merge(DataWidth'(evt_mask_q), q_data_i, q_strb_i);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (trig_fire) state_d = START;
         START:   state_d = BUSY;
         BUSY:    if (job_done_i) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         rdy_q     <= 1'b0;
         p_valid_q <= 1'b0;
         p_data_q  <= '0;
      end else begin
         state_q   <= state_d;
         rdy_q     <= 1'b1;
         p_valid_q <= accept;
         p_data_q  <= rd_acc ? rdata : '0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         done_q     <= 1'b0;
         rej_q      <= 1'b0;
         cycles_q   <= '0;
         evt_mask_q <= '0;
         for (int unsigned i = 0; i < NumParams; i++) params_q[i] <= '0;
      end else begin
         // Set has priority over a same-cycle software clear.
         if (state_q == DONE)              done_q <= 1'b1;
         else if (clr_wr && q_data_i[0])   done_q <= 1'b0;

         if (trig_rej)                     rej_q <= 1'b1;
         else if (clr_wr && q_data_i[2])   rej_q <= 1'b0;

         if (trig_fire)                    cycles_q <= '0;
         else if (clr_wr && q_data_i[1])   cycles_q <= '0;
         else if (state_q == BUSY && cycles_q != '1) cycles_q <= cycles_q + 32'd1;

         if (wr_acc && off == 6'h04) evt_mask_q <= mask_wdata[NrCores-1:0];

         for (int unsigned i = 0; i < NumParams; i++) begin
            if (wr_acc && off == 6'(8 + i)) params_q[i] <= merge(params_q[i], q_data_i, q_strb_i);
         end
      end
   end

`ifdef HWPE_CTRL_ERR_EN
   logic err_d;
   logic p_err_q;

   always_comb begin
      err_d = 1'b0;
      if (!(off <= 6'h04 || is_param))                 err_d = 1'b1;
      if (q_write_i && (off == 6'h01 || off == 6'h03)) err_d = 1'b1;
      if (!q_write_i && (off == 6'h00 || off == 6'h02)) err_d = 1'b1;
      if (trig_rej)                                     err_d = 1'b1;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) p_err_q <= 1'b0;
      else       p_err_q <= accept & err_d;
   end

   assign p_err_o = p_err_q;
`endif

endmodule

// File: tb/tb_hwpe_ctrl_periph_slv.sv
// Directed self-checking bench for hwpe_ctrl_periph_slv (default parameters).
module tb_hwpe_ctrl_periph_slv;

   logic          clk = 1'b0;
   logic          rst;
   logic          q_valid, q_ready, q_write, p_valid, job_start, job_done;
   logic [31:0]   q_addr, q_data, p_data;
   logic [3:0]    q_strb;
   logic [255:0]  params;
   logic [8:0]    evt;
`ifdef HWPE_CTRL_ERR_EN
   logic          p_err;
`endif

   int            total = 0;
   int            passed = 0;
   int            starts = 0;
   int            evt_cnt = 0;
   logic [8:0]    evt_last = '0;
   logic          rsp_valid;
   logic [31:0]   rsp_data;
   logic          rsp_err;
   int            evc;

   hwpe_ctrl_periph_slv #(
      .AddrWidth(32), .DataWidth(32), .NrCores(9), .NumParams(8)
   ) dut (
      .clk_i(clk), .rst_i(rst),
      .q_valid_i(q_valid), .q_ready_o(q_ready), .q_addr_i(q_addr),
      .q_write_i(q_write), .q_data_i(q_data), .q_strb_i(q_strb),
      .p_valid_o(p_valid), .p_data_o(p_data),
      .job_start_o(job_start), .job_done_i(job_done),
      .params_o(params),
`ifdef HWPE_CTRL_ERR_EN
      .p_err_o(p_err),
`endif
      .evt_o(evt)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (job_start === 1'b1) starts++;
      if (evt !== '0) begin
         evt_cnt++;
         evt_last = evt;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Drives one request from posedge+1, returns at posedge+1 of the response cycle.
   task automatic access(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] s);
      int n;
      q_addr = a; q_write = w; q_data = d; q_strb = s; q_valid = 1'b1;
      n = 0;
      while (q_ready !== 1'b1 && n < 8) begin
         @(posedge clk); #1;
         n++;
      end
      chk("q_ready", {31'b0, q_ready}, 32'd1);
      @(posedge clk); #1;
      q_valid = 1'b0; q_write = 1'b0; q_strb = '0; q_data = '0;
      rsp_valid = p_valid;
      rsp_data  = p_data;
`ifdef HWPE_CTRL_ERR_EN
      rsp_err   = p_err;
`else
      rsp_err   = 1'b0;
`endif
   endtask

   task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
      access(a, 1'b0, '0, '0);
      chk({tag, "_pvalid"}, {31'b0, rsp_valid}, 32'd1);
      chk(tag, rsp_data, exp);
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      access(a, 1'b1, d, s);
      chk("wr_pvalid", {31'b0, rsp_valid}, 32'd1);
      chk("wr_pdata", rsp_data, 32'd0);
   endtask

   initial begin
      rst = 1'b1; q_valid = 1'b0; q_write = 1'b0; q_addr = '0; q_data = '0;
      q_strb = '0; job_done = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_q_ready", {31'b0, q_ready}, 32'd0);
      chk("rst_p_valid", {31'b0, p_valid}, 32'd0);
      chk("rst_evt", {23'b0, evt}, 32'd0);
      chk("rst_start", {31'b0, job_start}, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("first_q_ready", {31'b0, q_ready}, 32'd1);

      rd(32'h04, 32'h0, "status_rst");
      rd(32'h0C, 32'h0, "cycles_rst");
      @(posedge clk); #1;
      chk("p_valid_1cyc", {31'b0, p_valid}, 32'd0);

      // Byte-strobed param write
      wr(32'h20, 32'hDEADBEEF, 4'b0101);
      rd(32'h20, 32'h00AD00EF, "param0_strb");
      chk("params_o0", params[31:0], 32'h00AD00EF);
      rd(32'h00, 32'h0, "trigger_rd");

      // Job 1: done 10 cycles after start
      wr(32'h10, 32'h1FF, 4'hF);
      rd(32'h10, 32'h1FF, "evt_mask");
      wr(32'h00, 32'h1, 4'hF);
      chk("job_start", {31'b0, job_start}, 32'd1);
      chk("start_ready_low", {31'b0, q_ready}, 32'd0);
      @(posedge clk); #1;
      chk("job_start_1cyc", {31'b0, job_start}, 32'd0);
      rd(32'h04, 32'h1, "status_busy");
      repeat (8) @(posedge clk);
      #1 job_done = 1'b1;
      @(posedge clk); #1;
      job_done = 1'b0;
      chk("evt_done", {23'b0, evt}, 32'h1FF);
      @(posedge clk); #1;
      chk("evt_1cyc", {23'b0, evt}, 32'h0);
      chk("evt_cnt1", evt_cnt, 32'd1);
      chk("starts1", starts, 32'd1);
      rd(32'h0C, 32'd10, "cycles10");
      rd(32'h04, 32'h2, "status_done");

      // Job 2: rejected trigger while busy, then done/clear collision
      wr(32'h08, 32'h1, 4'h1);
      rd(32'h04, 32'h0, "status_clr_done");
      wr(32'h00, 32'h1, 4'hF);
      wr(32'h00, 32'h1, 4'hF);
      rd(32'h04, 32'h5, "status_rej");
      chk("starts2", starts, 32'd2);
      wr(32'h08, 32'h4, 4'h1);
      rd(32'h04, 32'h1, "status_rej_clr");
      job_done = 1'b1;
      @(posedge clk); #1;
      job_done = 1'b0;
      wr(32'h08, 32'h1, 4'h1);
      rd(32'h04, 32'h2, "done_set_wins");
      chk("evt_cnt2", evt_cnt, 32'd2);

      // Job 3: CYCLES cleared mid-busy, counting resumes
      wr(32'h00, 32'h1, 4'hF);
      @(posedge clk); #1;
      wr(32'h08, 32'h2, 4'h1);
      job_done = 1'b1;
      @(posedge clk); #1;
      job_done = 1'b0;
      @(posedge clk); #1;
      rd(32'h0C, 32'd1, "cycles_clr_busy");

      // Unmapped / illegal accesses
      access(32'h40, 1'b0, '0, '0);
      chk("unmapped_rd", rsp_data, 32'h0);
`ifdef HWPE_CTRL_ERR_EN
      chk("err_unmapped", {31'b0, rsp_err}, 32'd1);
`endif
      access(32'h0C, 1'b1, 32'hFFFFFFFF, 4'hF);
`ifdef HWPE_CTRL_ERR_EN
      chk("err_ro_wr", {31'b0, rsp_err}, 32'd1);
`endif
      rd(32'h0C, 32'd1, "cycles_ro");
`ifdef HWPE_CTRL_ERR_EN
      chk("err_ok_rd", {31'b0, rsp_err}, 32'd0);
`endif

      // job_done outside BUSY is ignored
      evc = evt_cnt;
      job_done = 1'b1;
      @(posedge clk); #1;
      job_done = 1'b0;
      @(posedge clk); #1;
      chk("done_idle_evt", evt_cnt, evc);
      rd(32'h04, 32'h2, "done_idle_status");

      // Job 4: reset mid-busy
      wr(32'h00, 32'h1, 4'hF);
      @(posedge clk); #1;
      @(posedge clk); #1;
      evc = evt_cnt;
      rst = 1'b1;
      #1;
      chk("rst_mid_evt", {23'b0, evt}, 32'h0);
      chk("rst_mid_ready", {31'b0, q_ready}, 32'd0);
      job_done = 1'b1;
      @(posedge clk); #1;
      job_done = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rst_mid_params", {31'b0, |params}, 32'd0);
      rd(32'h04, 32'h0, "rst_mid_status");
      @(posedge clk); #1;
      chk("rst_mid_evtcnt", evt_cnt, evc);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule
